mux2_rr_arbiter: RTL and testbench

// - Two-channel round-robin arbiter that sits directly upstream of the team's 2:1 mux cell.
// - Chooses one of two valid/ready requesters each cycle and drives the mux select (sel).
// - Registers the selected word into a one-entry output stage with a valid/ready handshake.
// - Lets a shared downstream consumer take the traffic of two producers.

---
 rtl/mux2_rr_arbiter.sv | 65 ++++++
 tb/tb_mux2_rr_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-channel round-robin arbiter feeding a one-entry registered output stage (optional grant counters under ARB_STATS_EN)
module mux2_rr_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  a_grants,
    output logic [CNT_W-1:0]  b_grants
`endif
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    state_t state, state_nxt;
    logic last, grant_v, grant_b, slot_free, accept;
    // grant selection, handshake readies and next output-stage state
    always_comb begin
        grant_v   = a_valid || b_valid;
        grant_b   = b_valid && (!a_valid || !last);
        slot_free = (state == EMPTY) || out_ready;
        a_ready   = slot_free && a_valid && !grant_b;
        b_ready   = slot_free && grant_b;
        accept    = a_ready || b_ready;
        sel       = grant_v ? grant_b : last;
        state_nxt = accept ? FULL : (out_ready ? EMPTY : state);
    end
    assign out_valid = (state == FULL);
    // output stage register; last starts at B so A wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            last     <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                out_data <= grant_b ? b_data : a_data;
                last     <= grant_b;
            end
        end
    end
`ifdef ARB_STATS_EN
    // per-channel acceptance counters, wrapping at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_grants <= '0;
            b_grants <= '0;
        end else begin
            a_grants <= a_grants + CNT_W'(a_ready);
            b_grants <= b_grants + CNT_W'(b_ready);
        end
    end
`endif
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed and random checks of mux2_rr_arbiter against a behavioural model
module tb_mux2_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ready, b_ready, sel, out_valid;
    logic [7:0] out_data;
`ifdef ARB_STATS_EN
    logic [15:0] a_grants, b_grants;
    logic [1:0]  a_grants2, b_grants2;
    logic        a_ready2, b_ready2, sel2, out_valid2;
    logic [7:0]  out_data2;
`endif

    int errors = 0;
    int checks = 0;

    // behavioural model: held word, last granted channel (0=A, 1=B), acceptance counts
    logic       m_valid;
    logic [7:0] m_data;
    int         last_ch;
    int         cnt_a, cnt_b;
    logic       acc_a, acc_b;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.DATA_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef ARB_STATS_EN
        , .a_grants(a_grants), .b_grants(b_grants)
`endif
    );

`ifdef ARB_STATS_EN
    mux2_rr_arbiter #(.DATA_W(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready2),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready2),
        .sel(sel2), .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
        .a_grants(a_grants2), .b_grants(b_grants2)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        last_ch = 1;
        cnt_a   = 0;
        cnt_b   = 0;
    endtask

    // one clock: drive inputs, check comb and registered outputs, advance the model
    task automatic cycle(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd, input logic ordy);
        int   winner;
        logic room;
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
        #1;
        room   = !m_valid || ordy;
        winner = (av && bv) ? 1 - last_ch : av ? 0 : bv ? 1 : -1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("out_data", {24'd0, out_data}, {24'd0, m_data});
        check("a_ready", {31'd0, a_ready}, {31'd0, room && winner == 0});
        check("b_ready", {31'd0, b_ready}, {31'd0, room && winner == 1});
        check("sel", {31'd0, sel}, (winner < 0) ? last_ch : winner);
        acc_a = room && winner == 0;
        acc_b = room && winner == 1;
        @(posedge clk);
        if (acc_a || acc_b) begin
            m_valid = 1'b1;
            m_data  = acc_b ? bd : ad;
            last_ch = winner;
            cnt_a  += int'(acc_a);
            cnt_b  += int'(acc_b);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic       pa, pb, av, bv;
        logic [7:0] ad, bd;
        model_reset();
        // reset state
        @(negedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        // single channel A
        cycle(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
        check("single_acc", {31'd0, acc_a}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        // contention from a fresh reset: A,B,A,B
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i), 1'b1);
            check("contend_order", {31'd0, acc_b}, i % 2);
        end
        // backpressure: hold everything for 3 cycles, then drain and accept together
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        check("bp_accept", {31'd0, acc_a}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 8'h22, 1'b0);
        // async reset while FULL
        check("full_before_rst", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_out_data", {24'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h5A, 1'b1, 8'hA5, 1'b1);
        check("post_rst_grant_a", {31'd0, acc_a}, 32'd1);
        // random traffic honouring valid/data hold until accepted
        pa = 1'b0; pb = 1'b0; ad = '0; bd = '0;
        for (int i = 0; i < 400; i++) begin
            av = pa ? 1'b1 : ($urandom % 4 != 0);
            bv = pb ? 1'b1 : ($urandom % 4 != 0);
            ad = pa ? ad : 8'($urandom);
            bd = pb ? bd : 8'($urandom);
            cycle(av, ad, bv, bd, $urandom % 4 != 0);
            pa = av && !acc_a;
            pb = bv && !acc_b;
        end
`ifdef ARB_STATS_EN
        check("a_grants", {16'd0, a_grants}, cnt_a % 65536);
        check("b_grants", {16'd0, b_grants}, cnt_b % 65536);
        check("a_grants_wrap", {30'd0, a_grants2}, cnt_a % 4);
        check("b_grants_wrap", {30'd0, b_grants2}, cnt_b % 4);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
